// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MULDIV issue front end: funct3 codes, FSM states,
// datapath widths and the result-select helper.
package mdu_issue_ctrl_pkg;

  localparam int REG_BUS   = 64;
  localparam int MD_CTRL_W = 8;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  // MUL and the quotients come back on data_1; high products and remainders on data_2.
  function automatic logic use_data_2(input logic [2:0] op);
    return (op != MDU_MUL) && (op != MDU_DIV) && (op != MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_opsel.sv
// Combinational operand decode: signedness, mul_en, W-variant operand
// extension and detection of the divide special cases.
module mdu_issue_ctrl_opsel
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] op_1,
  input  logic [XLEN-1:0] op_2,
  output logic [XLEN-1:0] ext_op_1,
  output logic [XLEN-1:0] ext_op_2,
  output logic            sign_1,
  output logic            sign_2,
  output logic            mul_en,
  output logic            div_by_zero,
  output logic            div_overflow
);

  logic [XLEN-1:0] min_neg;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sign_1 = 1'b0;
    sign_2 = 1'b0;
    unique case (op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        sign_1 = 1'b1;
        sign_2 = 1'b1;
      end
      MDU_MULHSU: sign_1 = 1'b1;
      default: ;
    endcase
  end

  assign mul_en = ~op[2];

  // W variants operate on the low word, extended according to the op's signedness.
  assign ext_op_1 = !word ? op_1 :
                    sign_1 ? {{(XLEN-32){op_1[31]}}, op_1[31:0]} : {{(XLEN-32){1'b0}}, op_1[31:0]};
  assign ext_op_2 = !word ? op_2 :
                    sign_2 ? {{(XLEN-32){op_2[31]}}, op_2[31:0]} : {{(XLEN-32){1'b0}}, op_2[31:0]};

  assign min_neg = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

  assign div_by_zero  = op[2] && (ext_op_2 == '0);
  assign div_overflow = op[2] && sign_1 && (ext_op_1 == min_neg) && (ext_op_2 == '1);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// EX-stage front end for MULDIV: decode, request handshake, stall and result hold.
// Define MDU_DIV_SHORTCUT_EN to resolve divide-by-zero and signed overflow locally.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int XLEN   = REG_BUS,
  parameter int CTRL_W = MD_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [2:0]        mdu_op_i,
  input  logic              word_i,
  input  logic [XLEN-1:0]   op_1_i,
  input  logic [XLEN-1:0]   op_2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  input  logic              wb_ready_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   result_o,
  output logic              result_valid_o,
  output logic              md_mul_en_o,
  output logic              md_req_valid_o,
  output logic [XLEN-1:0]   md_op_1_o,
  output logic [XLEN-1:0]   md_op_2_o,
  output logic              md_sign_op_1_o,
  output logic              md_sign_op_2_o,
  output logic [CTRL_W-1:0] md_ctrl_o,
  input  logic [XLEN-1:0]   md_data_1_i,
  input  logic [XLEN-1:0]   md_data_2_i,
  input  logic              md_ready_i,
  input  logic              md_valid_i
);

  state_e          state;
  logic [2:0]      op_q;
  logic            word_q;

  logic [XLEN-1:0] ext_op_1, ext_op_2;
  logic            sign_1, sign_2, mul_en;
  logic            div_by_zero, div_overflow;
  logic [XLEN-1:0] md_result;

  function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  mdu_issue_ctrl_opsel #(.XLEN(XLEN)) u_opsel (
    .op           (mdu_op_i),
    .word         (word_i),
    .op_1         (op_1_i),
    .op_2         (op_2_i),
    .ext_op_1     (ext_op_1),
    .ext_op_2     (ext_op_2),
    .sign_1       (sign_1),
    .sign_2       (sign_2),
    .mul_en       (mul_en),
    .div_by_zero  (div_by_zero),
    .div_overflow (div_overflow)
  );

  assign md_result = fmt_w(use_data_2(op_q) ? md_data_2_i : md_data_1_i, word_q);

`ifdef MDU_DIV_SHORTCUT_EN
  logic            take_shortcut;
  logic [XLEN-1:0] sc_quot, sc_rem, sc_result;

  assign take_shortcut = div_by_zero || div_overflow;
  assign sc_quot       = div_by_zero ? '1 : ext_op_1;
  assign sc_rem        = div_by_zero ? ext_op_1 : '0;
  assign sc_result     = fmt_w(use_data_2(mdu_op_i) ? sc_rem : sc_quot, word_i);
`else
  logic unused_sc_flags;
  assign unused_sc_flags = div_by_zero ^ div_overflow;
`endif

  assign stall_o = ((state == IDLE) && ex_valid_i) || (state == ISSUE) || (state == WAIT) ||
                   (state == DRAIN) || ((state == DONE) && !wb_ready_i);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= '0;
      word_q         <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      md_mul_en_o    <= 1'b0;
      md_req_valid_o <= 1'b0;
      md_op_1_o      <= '0;
      md_op_2_o      <= '0;
      md_sign_op_1_o <= 1'b0;
      md_sign_op_2_o <= 1'b0;
      md_ctrl_o      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_valid_i && !flush_i) begin
            op_q           <= mdu_op_i;
            word_q         <= word_i;
            md_mul_en_o    <= mul_en;
            md_op_1_o      <= ext_op_1;
            md_op_2_o      <= ext_op_2;
            md_sign_op_1_o <= sign_1;
            md_sign_op_2_o <= sign_2;
            md_ctrl_o      <= ctrl_i;
`ifdef MDU_DIV_SHORTCUT_EN
            if (take_shortcut) begin
              result_o       <= sc_result;
              result_valid_o <= 1'b1;
              state          <= DONE;
            end else begin
              md_req_valid_o <= 1'b1;
              state          <= ISSUE;
            end
`else
            md_req_valid_o <= 1'b1;
            state          <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          // Flush wins over a same-cycle accept; the request is simply withdrawn.
          if (flush_i) begin
            md_req_valid_o <= 1'b0;
            state          <= IDLE;
          end else if (md_ready_i) begin
            md_req_valid_o <= 1'b0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (flush_i && md_valid_i) begin
            state <= IDLE;
          end else if (flush_i) begin
            state <= DRAIN;
          end else if (md_valid_i) begin
            result_o       <= md_result;
            result_valid_o <= 1'b1;
            state          <= DONE;
          end
        end
        DRAIN: begin
          if (md_valid_i) state <= IDLE;
        end
        DONE: begin
          if (wb_ready_i || flush_i) begin
            result_valid_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed self-checking bench for mdu_issue_ctrl with a hand-driven MULDIV responder.
module tb_mdu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, word_i, flush_i, wb_ready_i;
  logic [2:0]  mdu_op_i;
  logic [63:0] op_1_i, op_2_i;
  logic [7:0]  ctrl_i;
  logic        stall_o, result_valid_o, md_mul_en_o, md_req_valid_o;
  logic [63:0] result_o, md_op_1_o, md_op_2_o;
  logic        md_sign_op_1_o, md_sign_op_2_o;
  logic [7:0]  md_ctrl_o;
  logic [63:0] md_data_1_i, md_data_2_i;
  logic        md_ready_i, md_valid_i;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  mdu_issue_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid_i),
    .mdu_op_i       (mdu_op_i),
    .word_i         (word_i),
    .op_1_i         (op_1_i),
    .op_2_i         (op_2_i),
    .ctrl_i         (ctrl_i),
    .flush_i        (flush_i),
    .wb_ready_i     (wb_ready_i),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .md_mul_en_o    (md_mul_en_o),
    .md_req_valid_o (md_req_valid_o),
    .md_op_1_o      (md_op_1_o),
    .md_op_2_o      (md_op_2_o),
    .md_sign_op_1_o (md_sign_op_1_o),
    .md_sign_op_2_o (md_sign_op_2_o),
    .md_ctrl_o      (md_ctrl_o),
    .md_data_1_i    (md_data_1_i),
    .md_data_2_i    (md_data_2_i),
    .md_ready_i     (md_ready_i),
    .md_valid_i     (md_valid_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single cycle; returns one cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [7:0] c);
    ex_valid_i = 1'b1;
    mdu_op_i   = op;
    word_i     = w;
    op_1_i     = a;
    op_2_i     = b;
    ctrl_i     = c;
    #1;
    check("stall_on_accept", stall_o, 1'b1);
    tick();
    ex_valid_i = 1'b0;
    op_1_i     = '0;
    op_2_i     = '0;
  endtask

  task automatic accept();
    md_ready_i = 1'b1;
    tick();
    md_ready_i = 1'b0;
    check("req_dropped_after_accept", md_req_valid_o, 1'b0);
  endtask

  task automatic respond(input logic [63:0] d1, input logic [63:0] d2);
    md_valid_i  = 1'b1;
    md_data_1_i = d1;
    md_data_2_i = d2;
    tick();
    md_valid_i  = 1'b0;
    md_data_1_i = '0;
    md_data_2_i = '0;
  endtask

  task automatic retire(input string tag, input logic [63:0] exp);
    check({tag, "_valid"}, result_valid_o, 1'b1);
    check({tag, "_result"}, result_o, exp);
    wb_ready_i = 1'b1;
    #1;
    check({tag, "_stall_released"}, stall_o, 1'b0);
    tick();
    wb_ready_i = 1'b0;
    check({tag, "_valid_cleared"}, result_valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {ex_valid_i, word_i, flush_i, wb_ready_i, md_ready_i, md_valid_i} = '0;
    mdu_op_i = '0; op_1_i = '0; op_2_i = '0; ctrl_i = '0;
    md_data_1_i = '0; md_data_2_i = '0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_stall", stall_o, 1'b0);
    check("reset_result", result_o, 64'h0);
    check("reset_result_valid", result_valid_o, 1'b0);
    check("reset_req_valid", md_req_valid_o, 1'b0);
    check("reset_md_op_1", md_op_1_o, 64'h0);

    // A stray MULDIV valid while idle has no effect.
    respond(64'd99, 64'd99);
    check("idle_valid_ignored", result_valid_o, 1'b0);
    check("idle_valid_no_stall", stall_o, 1'b0);

    // MULHU all-ones * 2: high product is 1.
    issue(3'b011, 1'b0, ONES, 64'd2, 8'h5A);
    check("mulhu_req", md_req_valid_o, 1'b1);
    check("mulhu_mul_en", md_mul_en_o, 1'b1);
    check("mulhu_sign_1", md_sign_op_1_o, 1'b0);
    check("mulhu_sign_2", md_sign_op_2_o, 1'b0);
    check("mulhu_op_1", md_op_1_o, ONES);
    check("mulhu_op_2", md_op_2_o, 64'd2);
    check("mulhu_ctrl", md_ctrl_o, 8'h5A);
    accept();
    respond(64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    retire("mulhu", 64'h1);

    // DIVW: low word sign-extended, quotient sign-extended from bit 31.
    issue(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 8'h01);
    check("divw_op_1", md_op_1_o, 64'hFFFF_FFFF_FFFF_FFF9);
    check("divw_op_2", md_op_2_o, 64'd2);
    check("divw_sign_1", md_sign_op_1_o, 1'b1);
    check("divw_sign_2", md_sign_op_2_o, 1'b1);
    check("divw_mul_en", md_mul_en_o, 1'b0);
    accept();
    respond(64'hABCD_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF);
    retire("divw", 64'hFFFF_FFFF_FFFF_FFFD);

    // REMU with MULDIV not ready for 3 cycles, then a 5-cycle writeback stall.
    issue(3'b111, 1'b0, 64'd100, 64'd7, 8'h33);
    for (int i = 0; i < 3; i++) begin
      check("remu_req_held", md_req_valid_o, 1'b1);
      check("remu_op_1_stable", md_op_1_o, 64'd100);
      check("remu_op_2_stable", md_op_2_o, 64'd7);
      check("remu_stall_issue", stall_o, 1'b1);
      tick();
    end
    accept();
    check("remu_stall_wait", stall_o, 1'b1);
    respond(64'd14, 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("done_hold_valid", result_valid_o, 1'b1);
      check("done_hold_result", result_o, 64'd2);
      check("done_hold_stall", stall_o, 1'b1);
      tick();
    end
    retire("remu", 64'd2);

    // DIVUW zero-extends; flush together with ready withdraws the request.
    issue(3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h1_0000_0003, 8'h02);
    check("divuw_op_1", md_op_1_o, 64'h0000_0000_8000_0000);
    check("divuw_op_2", md_op_2_o, 64'd3);
    check("divuw_sign_1", md_sign_op_1_o, 1'b0);
    flush_i = 1'b1;
    md_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    md_ready_i = 1'b0;
    check("issue_flush_req", md_req_valid_o, 1'b0);
    check("issue_flush_stall", stall_o, 1'b0);

    // Flush in WAIT drains the late response, then a fresh MUL 3*5.
    issue(3'b000, 1'b0, 64'd7, 64'd9, 8'h03);
    accept();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("drain_stall", stall_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("drain_no_valid", result_valid_o, 1'b0);
      tick();
    end
    respond(64'd63, 64'd0);
    check("drain_discard_valid", result_valid_o, 1'b0);
    check("drain_exit_stall", stall_o, 1'b0);
    issue(3'b000, 1'b0, 64'd3, 64'd5, 8'h04);
    accept();
    respond(64'd15, 64'd0);
    retire("mul_after_drain", 64'd15);

    // Flush and response in the same WAIT cycle: result dropped.
    issue(3'b110, 1'b0, 64'd10, 64'd3, 8'h05);
    accept();
    flush_i = 1'b1;
    md_valid_i = 1'b1;
    md_data_2_i = 64'd1;
    tick();
    flush_i = 1'b0;
    md_valid_i = 1'b0;
    check("wait_flush_valid_drop", result_valid_o, 1'b0);
    check("wait_flush_valid_stall", stall_o, 1'b0);

    // Flush in DONE retires without writeback.
    issue(3'b000, 1'b0, 64'd2, 64'd2, 8'h06);
    accept();
    respond(64'd4, 64'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("done_flush_valid", result_valid_o, 1'b0);

`ifdef MDU_DIV_SHORTCUT_EN
    issue(3'b100, 1'b0, 64'd123, 64'd0, 8'h07);
    check("dbz_no_req", md_req_valid_o, 1'b0);
    retire("dbz_short", ONES);
    issue(3'b100, 1'b0, MIN_NEG, ONES, 8'h08);
    check("ovf_no_req", md_req_valid_o, 1'b0);
    retire("ovf_short", MIN_NEG);
    issue(3'b110, 1'b1, 64'h0000_0000_8000_0005, 64'h0, 8'h09);
    check("remw_dbz_no_req", md_req_valid_o, 1'b0);
    retire("remw_dbz_short", 64'hFFFF_FFFF_8000_0005);
`else
    issue(3'b100, 1'b0, 64'd123, 64'd0, 8'h07);
    check("dbz_issued", md_req_valid_o, 1'b1);
    accept();
    respond(ONES, 64'd123);
    retire("dbz_issued", ONES);
    issue(3'b100, 1'b0, MIN_NEG, ONES, 8'h08);
    check("ovf_issued", md_req_valid_o, 1'b1);
    accept();
    respond(MIN_NEG, 64'd0);
    retire("ovf_issued", MIN_NEG);
`endif

    // Asynchronous reset mid-WAIT clears outputs without waiting for an edge.
    issue(3'b001, 1'b0, 64'd5, 64'd6, 8'hC3);
    accept();
    check("pre_reset_stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_stall", stall_o, 1'b0);
    check("async_rst_req", md_req_valid_o, 1'b0);
    check("async_rst_result_valid", result_valid_o, 1'b0);
    check("async_rst_result", result_o, 64'h0);
    check("async_rst_op_1", md_op_1_o, 64'h0);
    check("async_rst_ctrl", md_ctrl_o, 8'h0);
    check("async_rst_mul_en", md_mul_en_o, 1'b0);
    tick();
    rst = 1'b0;
    respond(64'd30, 64'd0);
    check("post_reset_idle", result_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
